// File: rtl/bcd_seq_adder.sv
// bcd_seq_adder: digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
module bcd_seq_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_r, b_r, res, res_n;
  logic            sub_r, carry, inv_acc;
  logic [IW-1:0]   idx;
  logic [3:0]      ad, bdr, bd, dig;
  logic [4:0]      t;
  logic            last, bad, c_n;

  // subtraction is a + nines-complement(b) + 1, the +1 entering as the initial carry
  always_comb begin
    ad    = a_r[4*idx +: 4];
    bdr   = b_r[4*idx +: 4];
    bd    = sub_r ? 4'd9 - bdr : bdr;
    t     = {1'b0, ad} + {1'b0, bd} + {4'd0, carry};
    c_n   = t > 5'd9;
    dig   = c_n ? 4'(t + 5'd6) : t[3:0];
    bad   = (ad > 4'd9) || (bdr > 4'd9);
    last  = idx == IW'(DIGITS - 1);
    res_n = res;
    res_n[4*idx +: 4] = dig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
      carry   <= 1'b0;
      idx     <= '0;
      res     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      inv_acc <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r     <= a;
          b_r     <= b;
          sub_r   <= sub;
          carry   <= sub ? 1'b1 : cin;
          idx     <= '0;
          inv_acc <= 1'b0;
          state   <= RUN;
          ready   <= 1'b0;
          busy    <= 1'b1;
        end
        RUN: begin
          res     <= res_n;
          carry   <= c_n;
          idx     <= idx + 1'b1;
          inv_acc <= inv_acc | bad;
          if (last) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= res_n;
            cout    <= c_n;
            invalid <= inv_acc | bad;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_seq_adder.sv
// tb_bcd_seq_adder: scoreboard bench; expectations come from integer arithmetic on decoded BCD values.
module tb_bcd_seq_adder;
  localparam int D = 4;
  localparam int W = 4 * D;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         inv;
    int           cyc;
  } exp_t;

  logic         clk = 0, rst = 1, start = 0, sub = 0, cin = 0;
  logic [W-1:0] a = '0, b = '0;
  logic         ready, busy, done, cout, invalid;
  logic [W-1:0] sum;

  int   checks = 0, errors = 0, ncyc = 0;
  exp_t q[$];

  bcd_seq_adder #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint bcd2i(input logic [W-1:0] v);
    longint r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] i2bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input int cyc);
    exp_t   e;
    longint m = 1, r;
    for (int i = 0; i < D; i++) m = m * 10;
    e.inv = 1'b0;
    for (int i = 0; i < D; i++) if (x[4*i +: 4] > 9 || y[4*i +: 4] > 9) e.inv = 1'b1;
    if (s) begin
      r   = bcd2i(x) - bcd2i(y);
      e.c = r >= 0;
      e.s = i2bcd((r + m) % m);
    end else begin
      r   = bcd2i(x) + bcd2i(y) + longint'(ci);
      e.c = r >= m;
      e.s = i2bcd(r % m);
    end
    e.cyc = cyc;
    return e;
  endfunction

  // monitor: every done pops one expectation; the status flags must be one-hot outside reset
  always @(negedge clk) begin
    exp_t e;
    int   n;
    ncyc++;
    if (!rst) begin
      n = ready + busy + done;
      chk("status_onehot", W'(n), W'(1));
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", ncyc);
        end else begin
          e = q.pop_front();
          chk("done_latency", W'(ncyc), W'(e.cyc));
          chk("invalid", W'(invalid), W'(e.inv));
          if (!e.inv) begin
            chk("sum", sum, e.s);
            chk("cout", W'(cout), W'(e.c));
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk); #1;
    while (!ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 50 cycles");
    end
  endtask

  task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input bit restart = 0);
    wait_ready();
    if (!ready) return;
    sub = s; a = x; b = y; cin = ci; start = 1;
    q.push_back(model(s, x, y, ci, ncyc + D + 1));
    @(negedge clk); #1;
    start = 0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    if (restart) begin
      start = 1;
      @(negedge clk); #1;
      start = 0;
    end
  endtask

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 7) == 0) r[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", W'(ready), W'(1));
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    chk("reset_sum", sum, '0);
    chk("reset_cout", W'(cout), W'(0));
    chk("reset_invalid", W'(invalid), W'(0));
    rst = 0;

    issue(0, 16'h1234, 16'h5678, 0);
    issue(0, 16'h9999, 16'h0001, 0);
    issue(0, 16'h0999, 16'h0000, 1);
    issue(1, 16'h5000, 16'h1234, 0);
    issue(1, 16'h1234, 16'h5000, 0);
    issue(1, 16'h4321, 16'h4321, 1);
    issue(0, 16'h12A4, 16'h0000, 0);
    issue(0, 16'h0001, 16'h0002, 0);
    issue(0, 16'h1111, 16'h2222, 0, 1);

    // abort mid-operation: two digits processed, then reset
    wait_ready();
    sub = 0; a = 16'h8765; b = 16'h4321; cin = 0; start = 1;
    @(negedge clk); #1;
    start = 0;
    repeat (2) begin @(negedge clk); #1; end
    chk("pre_abort_busy", W'(busy), W'(1));
    rst = 1;
    #1;
    chk("abort_ready", W'(ready), W'(1));
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_sum", sum, '0);
    chk("abort_cout", W'(cout), W'(0));
    @(negedge clk); #1;
    chk("abort_held_done", W'(done), W'(0));
    rst = 0;
    issue(0, 16'h0001, 16'h0001, 0);

    for (int i = 0; i < 60; i++)
      issue(1'($urandom), rand_bcd(1), rand_bcd(1), 1'($urandom), ($urandom_range(0, 9) == 0));

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", q.size());
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_seq_adder.md
BCD_SEQ_ADDER -- requirements
Module: bcd_seq_adder

Interface
REQ-001 The block SHALL have one parameter, DIGITS (default 4): the number of BCD digits per operand, with a legal range of 1..16.
REQ-002 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  operation request, sampled only in IDLE.
REQ-005 sub  input  1  mode select: 0 = add (a+b+cin), 1 = subtract (a-b).
REQ-006 a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
REQ-007 b  input  4*DIGITS  operand B, packed BCD.
REQ-008 cin  input  1  carry-in, used in add mode only.
REQ-009 ready  output  1  high while in IDLE.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  one-cycle pulse marking a valid result.
REQ-012 sum  output  4*DIGITS  registered BCD result.
REQ-013 cout  output  1  add mode: decimal carry-out; subtract mode: 1 = no borrow.
REQ-014 invalid  output  1  high if any operand digit exceeded 9.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
- IDLE->RUN when start=1.
- RUN->DONE after DIGITS digit steps.
- DONE->IDLE unconditionally after one cycle.
REQ-016 On the edge that accepts start, the block SHALL latch a, b, sub and cin, set the digit index to 0, and clear the invalid accumulator.
- Initial carry = cin when sub=0.
- Initial carry = 1 when sub=1; cin is ignored.
REQ-017 start SHALL be ignored in RUN and DONE; operand inputs SHALL be don't-care outside the accepting edge.
REQ-018 Each RUN edge SHALL process one digit, least significant first, as follows.
- bd = b digit (add) or 9-b digit (subtract).
- t = a digit + bd + carry, 5-bit unsigned.
- If t>9: result digit = (t+6)[3:0] and carry = 1; otherwise result digit = t[3:0] and carry = 0.
REQ-019 Result digit i SHALL be written to internal position i; the carry SHALL be held in a register between digits (ripple across time, not across logic).
REQ-020 On the final RUN edge, sum SHALL take the full internal result, cout SHALL take the final carry, and done SHALL assert for exactly the following cycle.
- Latency: done is high DIGITS clock cycles after the start-accepting edge.
REQ-021 sum, cout and invalid SHALL hold their values from done until the next done or reset.
REQ-022 The subtract result SHALL be the ten's complement when a<b: sum = 10^DIGITS + a - b, with cout = 0.
REQ-023 If any latched a digit or b digit exceeds 9, invalid SHALL be 1 when done asserts.
- sum and cout are then unspecified, but the FSM timing SHALL be unchanged.
REQ-024 ready SHALL be 1 only in IDLE, busy SHALL be 1 only in RUN, and ready, busy and done SHALL be mutually exclusive.
REQ-025 A new start SHALL be accepted no earlier than the cycle after done, giving a throughput of one operation per DIGITS+2 cycles.

Reset
REQ-026 When rst is asserted, the block SHALL immediately enter IDLE and clear sum, cout, invalid, the carry, the digit index and the internal result.
- Outputs after reset: ready=1, busy=0, done=0.
REQ-027 If rst asserts during RUN or DONE, the operation SHALL be discarded with no done pulse, and the first start after rst deasserts SHALL be accepted normally.

Verification (DIGITS=4)
REQ-028 add a=0x1234, b=0x5678, cin=0 -> sum=0x6912, cout=0, invalid=0; done exactly 4 cycles after start accepted; busy high for 4 cycles.
REQ-029 add a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1; add a=0x0999, b=0x0000, cin=1 -> sum=0x1000, cout=0.
REQ-030 sub a=0x5000, b=0x1234 -> sum=0x3766, cout=1; sub a=0x1234, b=0x5000 -> sum=0x6234, cout=0; sub a=b=0x4321 -> sum=0x0000, cout=1.
REQ-031 add a=0x12A4, b=0x0000 -> invalid=1 with done; the next valid operation -> invalid=0.
REQ-032 start pulsed again during RUN -> ignored, a single done pulse, result of the first operands only.
REQ-033 rst asserted in RUN after 2 digits -> immediately ready=1, sum=0, cout=0, no done; a subsequent add of 0x0001+0x0001 -> sum=0x0002.
